dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller sitting between the MEM stage and the off-chip data memory. It services MEM-stage loads and stores and, on a miss, drives `stall_o`, which feeds `CacheStall_i` of every pipeline register, including MEM/WB. It also runs the line-granular handshake to data memory: dirty-line write-back, then line fill.

## Interface
- `NUM_LINES`, 32, number of cache lines; power of two.
- `LINE_BITS`, 256, line width in bits, equal to 8 words.
- `ADDR_W`, 32, byte-address width.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  1  MEM-stage access valid (MemRead | MemWrite).
- `write_i`  in  1  1 = store, 0 = load.
- `addr_i`  in  ADDR_W  byte address; bits [1:0] ignored.
- `wdata_i`  in  32  store data.
- `rdata_o`  out  32  load data, valid when `req_i & ~write_i & ~stall_o`.
- `stall_o`  out  1  freeze pipeline; to all `CacheStall_i`.
- `mem_en_o`  out  1  memory request valid.
- `mem_we_o`  out  1  1 = line write, 0 = line read.
- `mem_addr_o`  out  ADDR_W  line-aligned address; low 5 bits are 0.
- `mem_wdata_o`  out  LINE_BITS  line being written back.
- `mem_rdata_i`  in  LINE_BITS  fill data, valid with `mem_ack_i`.
- `mem_ack_i`  in  1  one-cycle completion pulse.
- `hit_cnt_o`, `miss_cnt_o`  out  32  statistics counters (see Configuration).

## Operation
- Address split with the defaults: offset [4:0], word select [4:2], index [9:5], tag [31:10]. The tag is `ADDR_W - log2(NUM_LINES) - 5` bits.
- Per line: valid bit, dirty bit, tag, data.
- A hit is `req_i` with a valid line whose tag matches, evaluated combinationally in IDLE.
- Load hit: `rdata_o` is driven combinationally from the selected word. No stall.
- Store hit: the word is written and dirty is set on the next rising edge. No stall.
- Miss: `stall_o` rises combinationally in the same cycle.
- FSM states (package enum):
  - IDLE: on miss, go to WB if the victim is valid and dirty, otherwise go to RD.
  - WB: `mem_en_o=1`, `mem_we_o=1`, address = {victim tag, index, 5'b0}, data = victim line. On `mem_ack_i`, go to RD.
  - RD: `mem_en_o=1`, `mem_we_o=0`, address = {req tag, index, 5'b0}. On `mem_ack_i`, write `mem_rdata_i` into the line, set valid, clear dirty, and go to FILL.
  - FILL: one cycle, `stall_o=1`. Then return to IDLE, where the still-held request now hits. A store hit sets dirty at that point.
- `stall_o` = (state != IDLE) | (IDLE & `req_i` & ~hit).
- Memory handshake:
  - `mem_en_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` stay stable from state entry until the edge that samples `mem_ack_i`=1.
  - `mem_en_o` is 0 in the cycle after ack.
  - Ack while `mem_en_o`=0 is ignored.
- `req_i` and `addr_i` are held stable by the stalled pipeline. The controller does not latch them, apart from the victim tag captured on IDLE exit.

## Timing
- Reset values:
  - `stall_o`=0, `mem_en_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `rdata_o`=0 when idle with no hit.
  - All valid and dirty bits are 0; counters are 0; state is IDLE.
- Reset asserted mid-WB or mid-RD aborts at once: `mem_en_o` drops asynchronously, there is no write-back, and cache contents are invalidated.
- Hit latency 0: data is in the same cycle.
- Clean miss with memory ack latency N: stall for N+2 cycles (the IDLE miss cycle, N cycles in RD, and FILL).
- Dirty miss with write-back latency M: stall for M+N+2 cycles.
- Ack arriving in the first cycle of WB or RD (N=1) is legal.
- `req_i`=0 in IDLE: no state change, `stall_o`=0.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_cnt_o` increments once per access that completes without having missed.
  - `miss_cnt_o` increments once per IDLE→WB/RD transition.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package `dcache_pkg` holds:
  - the state enum (IDLE, WB, RD, FILL);
  - the offset, index and tag width constants derived from the defaults;
  - the line-width constant.
- Sub-module `dcache_sram` holds the tag array (valid, dirty, tag) and the data array, with one read port and one write port. The write port carries a full-line fill or a single-word update with a dirty-set flag.
- `dcache_ctrl` contains the FSM, hit logic, word mux and counters.

## Test plan
- Cold load 0x0000_0040, memory ack after 5 cycles returning a line whose word 0 is 0x1234_5678 -> `stall_o` high 7 cycles, one RD request to 0x40, then `rdata_o`=0x1234_5678 with no stall.
- Store 0xDEAD_BEEF to 0x44 after that fill -> no stall. A load from 0x44 next cycle returns 0xDEAD_BEEF, with no memory traffic.
- Load 0x0000_0440 (same index, new tag) -> WB to 0x40 with word 1 = 0xDEAD_BEEF, then RD to 0x440, in that order, each held until its ack.
- Reset pulsed in the 2nd cycle of WB -> `mem_en_o`=0 and `stall_o`=0 immediately. A re-access to 0x40 afterwards misses cleanly with no WB.
- Spurious `mem_ack_i` in IDLE -> no state change and no array write.
- With `DCACHE_STATS_EN`: sequence of 3 misses and 4 hits -> `miss_cnt_o`=3, `hit_cnt_o`=4. Without the macro, both read 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and default geometry for the data cache
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

    localparam int OFF_W  = 5;
    localparam int IDX_W  = 5;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LINE_W = 256;

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty and data arrays, one async read port, one write port
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = LINE_W,
    parameter int IW        = IDX_W,
    parameter int TW        = TAG_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IW-1:0]        rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TW-1:0]        rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 we,
    input  logic                 fill,
    input  logic                 set_dirty,
    input  logic [IW-1:0]        wr_idx,
    input  logic [TW-1:0]        wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic [2:0]           wr_sel,
    input  logic [31:0]          wr_word
);

    logic [NUM_LINES-1:0] valid, dirty;
    logic [TW-1:0]        tags [NUM_LINES];
    logic [LINE_BITS-1:0] data [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = data[rd_idx];

    // Status bits: reset invalidates everything; a fill makes a line valid and clean
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (we) begin
            valid[wr_idx] <= valid[wr_idx] | fill;
            dirty[wr_idx] <= fill ? 1'b0 : (dirty[wr_idx] | set_dirty);
        end
    end

    // Payload: full-line fill with new tag, or single-word store update
    always_ff @(posedge clk_i) begin
        if (we && fill) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_line;
        end else if (we) begin
            data[wr_idx][{wr_sel, 5'b0} +: 32] <= wr_word;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back cache controller; DCACHE_STATS_EN adds hit/miss counters
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = LINE_W,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 write_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 stall_o,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = ADDR_W - IW - OFF_W;

    state_t               state, next;
    logic [IW-1:0]        idx;
    logic [TW-1:0]        tag, vtag, l_tag;
    logic [2:0]           sel;
    logic                 l_valid, l_dirty, hit, miss, arr_we, fill;
    logic [LINE_BITS-1:0] l_line;
    logic                 unused;

    assign idx     = addr_i[OFF_W +: IW];
    assign tag     = addr_i[ADDR_W-1 -: TW];
    assign sel     = addr_i[4:2];
    assign unused  = ^addr_i[1:0];
    assign hit     = (state == IDLE) && req_i && l_valid && (l_tag == tag);
    assign miss    = (state == IDLE) && req_i && !hit;
    assign rdata_o = hit ? l_line[{sel, 5'b0} +: 32] : 32'h0;

    dcache_sram #(.NUM_LINES(NUM_LINES), .LINE_BITS(LINE_BITS), .IW(IW), .TW(TW)) u_sram (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_idx(idx), .rd_valid(l_valid), .rd_dirty(l_dirty), .rd_tag(l_tag), .rd_line(l_line),
        .we(arr_we), .fill(fill), .set_dirty(write_i), .wr_idx(idx), .wr_tag(tag),
        .wr_line(mem_rdata_i), .wr_sel(sel), .wr_word(wdata_i)
    );

    // State register; reset aborts any in-flight memory transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next;
    end

    // Victim tag is captured as the miss leaves IDLE so WB keeps a stable address
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     vtag <= '0;
        else if (miss) vtag <= l_tag;
    end

    // Next state, memory handshake and array write enables
    always_comb begin
        next        = state;
        stall_o     = 1'b1;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        arr_we      = 1'b0;
        fill        = 1'b0;
        case (state)
            IDLE: begin
                stall_o = miss;
                arr_we  = hit && write_i;
                if (miss) next = (l_valid && l_dirty) ? WB : RD;
            end
            WB: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {vtag, idx, 5'b0};
                mem_wdata_o = l_line;
                if (mem_ack_i) next = RD;
            end
            RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = {tag, idx, 5'b0};
                arr_we     = mem_ack_i;
                fill       = mem_ack_i;
                if (mem_ack_i) next = FILL;
            end
            FILL: next = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        missed;
    logic [31:0] hc, mc;

    // The hit that completes a refilled access is not a fresh hit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            missed <= 1'b0;
            hc     <= '0;
            mc     <= '0;
        end else begin
            if (miss) begin
                missed <= 1'b1;
                mc     <= mc + {31'b0, mc != 32'hFFFF_FFFF};
            end
            if (hit) begin
                missed <= 1'b0;
                hc     <= hc + {31'b0, !missed && hc != 32'hFFFF_FFFF};
            end
        end
    end

    assign hit_cnt_o  = hc;
    assign miss_cnt_o = mc;
`else
    assign hit_cnt_o  = 32'h0;
    assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: transaction-level cache/memory model driving and checking dcache_ctrl
module tb_dcache_ctrl;

    logic         clk = 0, rst = 1, req = 0, write = 0, ack = 0;
    logic [31:0]  addr = 0, wdata = 0, rdata, mem_addr, hit_cnt, miss_cnt;
    logic         stall, mem_en, mem_we;
    logic [255:0] mem_wdata, mem_rdata = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(write), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall), .mem_en_o(mem_en),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(ack), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    int total = 0, bad = 0;

    logic         m_valid [32];
    logic         m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];
    logic [255:0] mem [int unsigned];
    int           m_hits = 0, m_misses = 0;

    logic         chk_on = 0, e_stall = 0, e_en = 0, e_we = 0, e_rd = 0;
    logic [31:0]  e_addr = 0, e_rdata = 0;
    logic [255:0] e_wdata = 0;

    int           cyc_n = 0, stall_cycles = 0, en_cycles = 0, wb_cycles = 0, last_wb = 0, last_rd = 0;
    logic [31:0]  wb_addr_seen = 0, rd_addr_seen = 0, last_rdata = 0;
    logic [255:0] wb_data_seen = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT against the model's expectations mid-cycle, and log traffic
    always @(negedge clk) begin
        cyc_n++;
        if (stall) stall_cycles++;
        if (mem_en) en_cycles++;
        if (mem_en && mem_we) begin
            wb_cycles++;
            last_wb      = cyc_n;
            wb_addr_seen = mem_addr;
            wb_data_seen = mem_wdata;
        end
        if (mem_en && !mem_we) begin
            last_rd      = cyc_n;
            rd_addr_seen = mem_addr;
        end
        if (chk_on) begin
            check("stall", stall, e_stall);
            check("mem_en", mem_en, e_en);
            if (e_en) begin
                check("mem_we", mem_we, e_we);
                check("mem_addr", mem_addr, e_addr);
                if (e_we) check("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_rd) begin
                check("rdata", rdata, e_rdata);
                last_rdata = rdata;
            end
        end
    end

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int j = 0; j < 8; j++) l[j*32 +: 32] = la ^ (j * 32'h0101_0101) ^ 32'hA5A5_0000;
        return l;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic idle();
        req = 0; ack = 0;
        e_stall = 0; e_en = 0; e_rd = 0;
    endtask

    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input int lwb, input int lrd);
        logic [4:0]  idx = a[9:5];
        logic [21:0] tg = a[31:10];
        logic [31:0] la = {a[31:5], 5'b0};
        logic [31:0] vla;
        req = 1; write = w; addr = a; wdata = d; ack = 0; e_rd = 0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            m_misses++;
            e_stall = 1; e_en = 0;
            cyc();
            if (m_valid[idx] && m_dirty[idx]) begin
                vla = {m_tag[idx], idx, 5'b0};
                for (int k = 1; k <= lwb; k++) begin
                    e_en = 1; e_we = 1; e_addr = vla; e_wdata = m_data[idx];
                    ack = (k == lwb);
                    cyc();
                end
                ack = 0;
                mem[vla] = m_data[idx];
            end
            for (int k = 1; k <= lrd; k++) begin
                e_en = 1; e_we = 0; e_addr = la;
                ack = (k == lrd);
                mem_rdata = (k == lrd) ? line_of(la) : {8{$urandom}};
                cyc();
            end
            ack = 0;
            m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tg; m_data[idx] = line_of(la);
            e_en = 0;
            cyc();
        end else begin
            m_hits++;
        end
        e_stall = 0; e_en = 0; e_rd = !w;
        e_rdata = m_data[idx][int'(a[4:2]) * 32 +: 32];
        cyc();
        if (w) begin
            m_data[idx][int'(a[4:2]) * 32 +: 32] = d;
            m_dirty[idx] = 1;
        end
        idle();
    endtask

    initial begin
        logic [255:0] l;
        int s0, e0, w0;
        model_reset();
        l = line_of(32'h40);
        l[31:0] = 32'h1234_5678;
        mem[32'h40] = l;

        #12;
        check("rst_stall", stall, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        cyc();
        rst = 0;
        chk_on = 1;
        cyc();

        s0 = stall_cycles; e0 = en_cycles;
        access(0, 32'h40, 0, 1, 5);
        check("cold_stall_cycles", stall_cycles - s0, 7);
        check("cold_rd_cycles", en_cycles - e0, 5);
        check("cold_rd_addr", rd_addr_seen, 32'h40);
        check("cold_rdata", last_rdata, 32'h1234_5678);

        s0 = stall_cycles; e0 = en_cycles;
        access(1, 32'h44, 32'hDEAD_BEEF, 1, 1);
        access(0, 32'h44, 0, 1, 1);
        check("store_hit_stall", stall_cycles - s0, 0);
        check("store_hit_traffic", en_cycles - e0, 0);
        check("load_after_store", last_rdata, 32'hDEAD_BEEF);

        access(0, 32'h440, 0, 3, 2);
        check("wb_addr", wb_addr_seen, 32'h40);
        l = wb_data_seen;
        check("wb_word1", l[63:32], 32'hDEAD_BEEF);
        check("rd_after_wb_addr", rd_addr_seen, 32'h440);
        check("wb_then_rd_order", last_rd - last_wb, 2);

        access(1, 32'h448, 32'hCAFE_0001, 1, 1);
        req = 1; write = 0; addr = 32'h40; e_stall = 1; e_en = 0; e_rd = 0;
        cyc();
        e_en = 1; e_we = 1; e_addr = 32'h440; e_wdata = m_data[2];
        cyc();
        cyc();
        #2;
        chk_on = 0;
        rst = 1;
        req = 0;
        #1;
        check("abort_mem_en", mem_en, 0);
        check("abort_stall", stall, 0);
        cyc();
        rst = 0;
        model_reset();
        idle();
        chk_on = 1;
        cyc();
        w0 = wb_cycles; e0 = en_cycles;
        access(0, 32'h40, 0, 1, 2);
        check("post_abort_no_wb", wb_cycles - w0, 0);
        check("post_abort_rd_cycles", en_cycles - e0, 2);

        ack = 1; mem_rdata = {8{$urandom}};
        addr = 32'h40;
        cyc();
        ack = 0;
        access(0, 32'h40, 0, 1, 1);
        check("spurious_ack_data", last_rdata, line_of(32'h40) & 256'hFFFF_FFFF);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 31) << 5) | ($urandom_range(0, 7) << 2);
            access($urandom_range(0, 1), a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) begin
                ack = $urandom_range(0, 1);
                mem_rdata = {8{$urandom}};
                cyc();
                ack = 0;
            end
        end

`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
`else
        check("hit_cnt_off", hit_cnt, 0);
        check("miss_cnt_off", miss_cnt, 0);
`endif
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
